// File: rtl/gba_obj_pkg.sv
// Shared types and constants for the OBJ pipeline's OAM storage and CPU/DMA port.
package gba_obj_pkg;

    localparam int OAM_WORDS = 256;
    localparam int OAM_IDX_W = $clog2(OAM_WORDS);

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } oam_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RDMOD = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } oam_port_state_t;

    // Bus size code 3 is reserved and behaves as a full word.
    function automatic oam_size_t decode_size(input logic [1:0] code);
        case (code)
            2'd0:    decode_size = BYTE;
            2'd1:    decode_size = HALF;
            default: decode_size = WORD;
        endcase
    endfunction

endpackage

// File: rtl/oam_ram.sv
// 256x32 true dual-port OAM array: port A read-only, port B read/write, both read-first.
module oam_ram #(
    parameter int WORDS = 256,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] addr_a,
    output logic [31:0]      q_a,
    input  logic [IDX_W-1:0] addr_b,
    input  logic             we_b,
    input  logic [31:0]      wdata_b,
    output logic [31:0]      q_b
);

    logic [31:0] mem [WORDS];

    // Array contents survive reset; only the output registers are cleared.
    always_ff @(posedge clock) begin
        if (we_b) begin
            mem[addr_b] <= wdata_b;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            q_a <= mem[addr_a];
            q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/oam_cpu_port.sv
// OAM storage plus the blanking-gated CPU/DMA port; halfword writes merge via read-modify-write.
module oam_cpu_port #(
    parameter int OAM_WORDS = 256
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [31:0]                   OAM_mem_addr,
    output logic [31:0]                   OAM_mem_data,
    input  logic                          bus_req,
    input  logic                          bus_write,
    input  logic [1:0]                    bus_size,
    input  logic [9:0]                    bus_addr,
    input  logic [31:0]                   bus_wdata,
    output logic                          bus_ack,
    output logic [31:0]                   bus_rdata,
    input  logic [15:0]                   dispcnt,
    input  logic                          hblank,
    input  logic                          vblank,
    output gba_obj_pkg::oam_port_state_t  debug_state
);
    import gba_obj_pkg::*;

    localparam int IDX_W = $clog2(OAM_WORDS);

    oam_port_state_t state, next;
    oam_size_t       lat_size;
    logic            lat_write;
    logic [9:1]      lat_addr;
    logic [31:0]     lat_wdata;
    logic [31:0]     rdata_hold;
    logic [31:0]     q_b;
    logic [31:0]     merged;
    logic [31:0]     wdata_b;
    logic            we_b;
    logic            win;
    logic            accept;

    assign win    = vblank | dispcnt[7] | (hblank & dispcnt[5]);
    assign accept = (state == IDLE) && bus_req && win;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!bus_write) begin
                        next = RDMOD;
                    end else begin
                        case (decode_size(bus_size))
                            WORD:    next = WRITE;
                            HALF:    next = RDMOD;
                            default: next = ACK;
                        endcase
                    end
                end
            end
            RDMOD:   next = (lat_write && lat_size == HALF) ? WRITE : ACK;
            WRITE:   next = IDLE;
            ACK:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    // The request is captured once; later window changes cannot abort it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_write  <= 1'b0;
            lat_size   <= BYTE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_hold <= '0;
        end else begin
            if (accept) begin
                lat_write <= bus_write;
                lat_size  <= decode_size(bus_size);
                lat_addr  <= bus_addr[9:1];
                lat_wdata <= bus_wdata;
            end
            if (state == ACK && !lat_write) begin
                rdata_hold <= q_b;
            end
        end
    end

    assign merged  = lat_addr[1] ? {lat_wdata[31:16], q_b[15:0]}
                                 : {q_b[31:16], lat_wdata[15:0]};
    assign wdata_b = (lat_size == WORD) ? lat_wdata : merged;
    assign we_b    = (state == WRITE);

    assign bus_ack     = (state == WRITE) || (state == ACK);
    assign bus_rdata   = (state == ACK && !lat_write) ? q_b : rdata_hold;
    assign debug_state = state;

    oam_ram #(
        .WORDS (OAM_WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .addr_a  (OAM_mem_addr[IDX_W+1:2]),
        .q_a     (OAM_mem_data),
        .addr_b  (lat_addr[IDX_W+1:2]),
        .we_b    (we_b),
        .wdata_b (wdata_b),
        .q_b     (q_b)
    );

    logic unused_bits;
    assign unused_bits = ^{OAM_mem_addr[31:IDX_W+2], OAM_mem_addr[1:0], bus_addr[0],
                           dispcnt[15:8], dispcnt[6], dispcnt[4:0]};

endmodule
